pipe_hazard_tracker: RTL
========================

// Module: pipe_hazard_tracker
// PURPOSE
//  Pipeline-side partner of the stall controller. It tracks the writeback tag of
//  each in-flight instruction (valid, RegWrite, dest) through the EX, MEM and WB
//  stages. It feeds those tags back to the stall controller and acts on its stall
//  request: freeze PC and IF/ID, and inject a bubble into ID/EX.
//  It also handles branch flush, stall/retire performance counters, and a
//  stall-deadlock watchdog.
// PARAMETERS
//  REG_AW     5   register-address width (dest tags)
//  CNT_W      32  width of the performance counters (saturating)
//  MAX_STALL  3   longest legal run of consecutive stall cycles; exceeding it is a deadlock
// PORTS
//  clk              in   1        pipeline clock, single domain
//  rst              in   1        synchronous, active-high reset
//  ip_stall         in   1        stall request from the stall controller (ID hazard)
//  ip_flush         in   1        branch taken: squash IF/ID and the ID instruction
//  ip_valid_ID      in   1        ID stage holds a real instruction
//  ip_RegWrite_ID   in   1        ID instruction writes the register file
//  ip_dest_ID       in   REG_AW   ID instruction destination register
//  op_PC_write      out  1        PC update enable
//  op_IFID_write    out  1        IF/ID load enable
//  op_IFID_flush    out  1        clear IF/ID to NOP
//  op_bubble_EX     out  1        ID/EX loads a NOP this cycle
//  op_RegWrite_EX/_MEM/_WB  out 1       stage RegWrite tags (to the stall controller)
//  op_dest_EX/_MEM/_WB      out REG_AW  stage dest tags (to the stall controller)
//  op_stall_cycles  out  CNT_W    count of cycles stalled
//  op_retired       out  CNT_W    count of valid instructions leaving WB
//  op_deadlock      out  1        sticky watchdog flag
// BEHAVIOUR
//  Reset: every stage tag is valid=0, RegWrite=0, dest=0. Both counters are 0,
//   op_deadlock=0, FSM=RUN. While rst=1: op_PC_write=0, op_IFID_write=0,
//   op_IFID_flush=0, op_bubble_EX=1.
//  Effective stall: eff_stall = ip_stall & ~ip_flush. Flush wins, because the
//   stalled ID instruction is being squashed.
//  Combinational enables (rst=0):
//   - op_PC_write = op_IFID_write = ~eff_stall
//   - op_IFID_flush = ip_flush
//   - op_bubble_EX = ip_stall | ip_flush | ~ip_valid_ID
//  Tag pipeline, every rising edge (no stage ever holds):
//   - WB<=MEM, MEM<=EX.
//   - EX <= bubble ? {0,0,0} : {1, ip_RegWrite_ID & (ip_dest_ID!=0), ip_dest_ID}.
//   - A write to $0 is always tagged RegWrite=0.
//  Latency: an instruction accepted at edge k is in EX after k, MEM after k+1,
//   WB after k+2. op_retired increments at edge k+3, when valid leaves WB.
//  Counters:
//   - op_stall_cycles +1 on each edge with eff_stall=1.
//   - Both counters saturate at 2^CNT_W-1 (no wrap).
//  FSM (registered state, run counter run_cnt):
//   - RUN: eff_stall -> STALL with run_cnt=1; else stay in RUN.
//   - STALL: eff_stall=0 -> RUN with run_cnt=0.
//   - STALL: eff_stall=1 and run_cnt<MAX_STALL -> run_cnt+1.
//   - STALL: eff_stall=1 and run_cnt==MAX_STALL -> DEAD; op_deadlock=1 from the next cycle.
//   - DEAD: sticky until rst. Stall/flush handling continues normally; only the flag persists.
//   - ip_flush in STALL -> RUN, run_cnt=0.
//  Reset mid-stall: all tags, the FSM and the flag clear on that edge.
//   No partial shift occurs.
// TESTING
//  T1: rst for 2 cycles -> all tags 0, counters 0, op_bubble_EX=1, op_PC_write=0.
//  T2: issue dest=5/RegWrite=1, then ip_stall=1 for 3 cycles.
//   -> op_dest_EX=5, then MEM=5, then WB=5 on successive cycles.
//   -> op_PC_write=0 for those 3 cycles, 3 bubbles inserted.
//   -> op_stall_cycles=3, FSM back to RUN, op_deadlock=0.
//  T3: ip_stall=1 and ip_flush=1 together.
//   -> op_PC_write=1, op_IFID_flush=1, op_bubble_EX=1, op_stall_cycles unchanged.
//  T4: ip_stall held for 5 cycles (MAX_STALL=3) -> op_deadlock rises after the
//   4th stall edge and stays 1 after the stall clears, until rst.
//  T5: 10 back-to-back valid instructions, no stalls -> op_retired=10 three
//   edges after the last issue. A dest=0 RegWrite=1 issue shows op_RegWrite_EX=0.
//  T6: rst asserted in STALL with dest=7 in MEM -> the next cycle has all tags 0,
//   FSM=RUN, counters 0.

Source files
------------

// File: rtl/pipe_hazard_tracker.sv
// Pipeline-side hazard tracker: carries stage writeback tags EX->MEM->WB, applies
// stall/flush enables, counts stalls and retirements, and flags stall deadlocks.
module pipe_hazard_tracker #(
    parameter int unsigned REG_AW    = 5,
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned MAX_STALL = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ip_stall,
    input  logic              ip_flush,
    input  logic              ip_valid_ID,
    input  logic              ip_RegWrite_ID,
    input  logic [REG_AW-1:0] ip_dest_ID,
    output logic              op_PC_write,
    output logic              op_IFID_write,
    output logic              op_IFID_flush,
    output logic              op_bubble_EX,
    output logic              op_RegWrite_EX,
    output logic              op_RegWrite_MEM,
    output logic              op_RegWrite_WB,
    output logic [REG_AW-1:0] op_dest_EX,
    output logic [REG_AW-1:0] op_dest_MEM,
    output logic [REG_AW-1:0] op_dest_WB,
    output logic [CNT_W-1:0]  op_stall_cycles,
    output logic [CNT_W-1:0]  op_retired,
    output logic              op_deadlock
);

    localparam int unsigned RUN_W = (MAX_STALL < 2) ? 1 : $clog2(MAX_STALL + 1);

    typedef enum logic [1:0] {S_RUN, S_STALL, S_DEAD} state_t;

    state_t            r_state;
    logic [RUN_W-1:0]  r_run_cnt;
    logic              r_deadlock;
    logic              r_valid_EX, r_valid_MEM, r_valid_WB;
    logic              r_rw_EX, r_rw_MEM, r_rw_WB;
    logic [REG_AW-1:0] r_dest_EX, r_dest_MEM, r_dest_WB;
    logic [CNT_W-1:0]  r_stall_cycles, r_retired;

    logic w_eff_stall;
    logic w_bubble;

    // A flush squashes the stalled ID instruction, so it overrides the stall.
    assign w_eff_stall = ip_stall & ~ip_flush;
    assign w_bubble    = ip_stall | ip_flush | ~ip_valid_ID;

    assign op_PC_write   = ~rst & ~w_eff_stall;
    assign op_IFID_write = ~rst & ~w_eff_stall;
    assign op_IFID_flush = ~rst & ip_flush;
    assign op_bubble_EX  = rst | w_bubble;

    assign op_RegWrite_EX  = r_rw_EX;
    assign op_RegWrite_MEM = r_rw_MEM;
    assign op_RegWrite_WB  = r_rw_WB;
    assign op_dest_EX      = r_dest_EX;
    assign op_dest_MEM     = r_dest_MEM;
    assign op_dest_WB      = r_dest_WB;
    assign op_stall_cycles = r_stall_cycles;
    assign op_retired      = r_retired;
    assign op_deadlock     = r_deadlock;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid_EX  <= 1'b0;
            r_valid_MEM <= 1'b0;
            r_valid_WB  <= 1'b0;
            r_rw_EX     <= 1'b0;
            r_rw_MEM    <= 1'b0;
            r_rw_WB     <= 1'b0;
            r_dest_EX   <= '0;
            r_dest_MEM  <= '0;
            r_dest_WB   <= '0;
        end else begin
            r_valid_WB  <= r_valid_MEM;
            r_rw_WB     <= r_rw_MEM;
            r_dest_WB   <= r_dest_MEM;
            r_valid_MEM <= r_valid_EX;
            r_rw_MEM    <= r_rw_EX;
            r_dest_MEM  <= r_dest_EX;
            if (w_bubble) begin
                r_valid_EX <= 1'b0;
                r_rw_EX    <= 1'b0;
                r_dest_EX  <= '0;
            end else begin
                r_valid_EX <= 1'b1;
                r_rw_EX    <= ip_RegWrite_ID & (ip_dest_ID != '0);
                r_dest_EX  <= ip_dest_ID;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_retired      <= '0;
        end else begin
            if (w_eff_stall && (r_stall_cycles != '1))
                r_stall_cycles <= r_stall_cycles + 1'b1;
            if (r_valid_WB && (r_retired != '1))
                r_retired <= r_retired + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_RUN;
            r_run_cnt  <= '0;
            r_deadlock <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_eff_stall) begin
                        r_state   <= S_STALL;
                        r_run_cnt <= RUN_W'(1);
                    end
                end
                S_STALL: begin
                    if (!w_eff_stall) begin
                        r_state   <= S_RUN;
                        r_run_cnt <= '0;
                    end else if (r_run_cnt < RUN_W'(MAX_STALL)) begin
                        r_run_cnt <= r_run_cnt + 1'b1;
                    end else begin
                        r_state    <= S_DEAD;
                        r_deadlock <= 1'b1;
                    end
                end
                S_DEAD: begin
                    r_state    <= S_DEAD;
                    r_deadlock <= 1'b1;
                end
                default: begin
                    r_state   <= S_RUN;
                    r_run_cnt <= '0;
                end
            endcase
        end
    end

endmodule
